// File: rtl/fetch2.sv
// Second fetch stage: registers the fetch pair, predecodes branches,
// pushes to the instruction queue and flags predictor false hits.
module fetch2 (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  in_pc_valid,
    input  logic [31:0] in_pc,
    input  logic [63:0] in_data,
    input  logic        in_is_ds,
    input  logic        in_bp_taken,
    input  logic [31:0] in_bp_target,
    input  logic        flush,
    input  logic        queue_full,
    output logic [1:0]  push_valid,
    output logic [31:0] push_pc0,
    output logic [31:0] push_pc1,
    output logic [31:0] push_instr0,
    output logic [31:0] push_instr1,
    output logic        push_is_ds0,
    output logic        push_bp_taken,
    output logic [31:0] push_bp_target,
    output logic        bp_bypass_valid,
    output logic [31:0] bp_bypass_pc,
    output logic        bp_bypass_second_is_branch,
    output logic        f2_flush,
    output logic [31:0] f2_flush_pc
);

    logic        r_valid;
    logic [1:0]  r_mask;
    logic [31:0] r_pc;
    logic [63:0] r_data;
    logic        r_is_ds;
    logic        r_bp_taken;
    logic [31:0] r_bp_target;

    logic        push;
    logic        accept;
    logic        br0;
    logic        br1;

    function automatic logic is_branch(input logic [31:0] ins);
        logic r;
        r = 1'b0;
        case (ins[31:26])
            6'b000100, 6'b000101,
            6'b000110, 6'b000111,
            6'b000010, 6'b000011: r = 1'b1;
            6'b000001: r = (ins[19:17] == 3'b000);
            6'b000000: r = (ins[5:1] == 5'b00100);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // REGIMM rt in {00000,00001,10000,10001}: bits [19:17] must be zero
    assign br0 = r_valid && r_mask[0] && is_branch(r_data[31:0]);
    assign br1 = r_valid && r_mask[1] && is_branch(r_data[63:32]);

    assign push     = r_valid && !queue_full && !flush;
    assign f2_flush = push && r_bp_taken && !br0 && !br1;
    assign accept   = !flush && !queue_full && !f2_flush
                      && (in_pc_valid != 2'b00);

    always_ff @(posedge clk) begin
        if (!resetn || flush || (!queue_full && !accept)) begin
            r_valid     <= 1'b0;
            r_mask      <= 2'b00;
            r_pc        <= 32'h0;
            r_data      <= 64'h0;
            r_is_ds     <= 1'b0;
            r_bp_taken  <= 1'b0;
            r_bp_target <= 32'h0;
        end else if (accept) begin
            r_valid     <= 1'b1;
            r_mask      <= in_pc_valid;
            r_pc        <= in_pc;
            r_data      <= in_data;
            r_is_ds     <= in_is_ds;
            r_bp_taken  <= in_bp_taken;
            r_bp_target <= in_bp_target;
        end
    end

    assign push_valid     = push ? r_mask : 2'b00;
    assign push_pc0       = r_pc;
    assign push_pc1       = r_valid ? r_pc + 32'd4 : 32'h0;
    assign push_instr0    = r_data[31:0];
    assign push_instr1    = r_data[63:32];
    assign push_is_ds0    = r_is_ds;
    assign push_bp_taken  = r_bp_taken;
    assign push_bp_target = r_bp_target;

    assign bp_bypass_valid            = push_valid[1] && br1;
    assign bp_bypass_second_is_branch = br1;
    assign bp_bypass_pc               = r_pc;
    assign f2_flush_pc = f2_flush ? r_pc + 32'd8 : 32'h0;

endmodule

// File: doc/fetch2.md
# fetch2

Second instruction-fetch stage. It registers the aligned 8-byte fetch pair produced by fetch1 and predecodes both slots for MIPS branch/jump opcodes. It pushes valid instructions into the instruction queue and returns same-cycle delay-slot information (bypass) to fetch1. On a predictor false hit (predicted taken with no branch in the pair) it issues a one-cycle redirect (`f2_flush`) to fetch1.

## Interface
- No parameters.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_pc_valid  in  2  fetch1 `PC_valid`:
  - 11 = both slots valid
  - 10 = slot1 only
  - 00 = none
- in_pc  in  32  pair base PC, bits[2:0]=0
- in_data  in  64  instruction pair; slot0 = [31:0], slot1 = [63:32]
- in_is_ds  in  1  slot0 is the delay slot of the previous pair's slot1 branch
- in_bp_taken  in  1  predictor taken for this pair
- in_bp_target  in  32  predicted target
- flush  in  1  any backend redirect (BRU fail, eret, cp0, decode flush)
- queue_full  in  1  instruction queue cannot accept
- push_valid  out  2  per-slot push strobe
- push_pc0, push_pc1  out  32  slot PCs (base, base+4)
- push_instr0, push_instr1  out  32  slot instructions
- push_is_ds0  out  1  registered in_is_ds
- push_bp_taken  out  1  registered in_bp_taken
- push_bp_target  out  32  registered in_bp_target
- bp_bypass_valid  out  1  bypass record valid this cycle
- bp_bypass_pc  out  32  base PC of the pushed pair
- bp_bypass_second_is_branch  out  1  slot1 is a branch/jump
- f2_flush  out  1  redirect fetch1
- f2_flush_pc  out  32  redirect target

## Operation
- Stage register holds: valid flag, slot mask, pc, data, is_ds, bp_taken, bp_target.
- Accept: when `flush`=0, `queue_full`=0, and `in_pc_valid`≠00, capture inputs and set valid.
  - If `queue_full`=1, input is dropped; fetch1 re-presents it.
  - If not accepting, the register clears unless it is held.
- Hold: while `queue_full`=1 the register keeps its contents; all push, bypass and flush outputs are 0.
- Push: `push_valid` = `reg_mask` when reg valid, `queue_full`=0 and `flush`=0; otherwise 00. After a push the register either reloads (if accepting) or clears.
- Predecode (per valid slot). `is_branch` is true for:
  - opcode 000100, 000101, 000110, 000111, 000010, 000011
  - opcode 000001 with rt ∈ {00000, 00001, 10000, 10001}
  - opcode 000000 with funct ∈ {001000, 001001}
- Bypass: `bp_bypass_valid` = push of slot1 (push_valid[1]=1) and slot1 `is_branch`. `bp_bypass_second_is_branch` = slot1 `is_branch`; `bp_bypass_pc` = reg pc.
- False hit: reg bp_taken=1, no valid slot `is_branch`, and a push is occurring → `f2_flush`=1, `f2_flush_pc` = reg pc + 8 (32-bit wrap). The pushed pair is still pushed; input present that cycle is dropped.
- Priority, highest first:
  1. `flush`: register cleared, nothing pushed, no bypass, no `f2_flush`.
  2. `queue_full`: hold.
  3. `f2_flush`.
  4. Normal accept.

## Timing
- Reset: register invalid.
  - push_valid = 00; bp_bypass_valid = 0; f2_flush = 0.
  - All data outputs 0.
- Latency: 1 cycle from fetch1 output to push.
- Push, bypass and f2_flush are combinational from the stage register plus `flush`/`queue_full`, so fetch1 sees them the same cycle.
- f2_flush lasts exactly one cycle per offending pair; the register does not re-fire it because it is cleared or replaced.
- Throughput: one pair per cycle when the queue is not full.
- Reset mid-hold: discards the held pair.

## Test plan
- Sequential flow:
  - Pairs at 0xbfc00000 and 0xbfc00008 with mask 11, non-branch: push_valid=11 one cycle after each.
  - push_pc1 = 0xbfc00004 for the first pair.
- Slot1 beq:
  - Pair at 0x1000, slot1 = 0x10000003: next cycle bp_bypass_valid=1, second_is_branch=1, bp_bypass_pc=0x1000.
  - Slot0 beq only: bypass_valid=0.
- False hit: pair at 0x2000, bp_taken=1, target 0x3000, both slots addu → push_valid=11, f2_flush=1, f2_flush_pc=0x2008, for one cycle.
- Mask 10 at 0x4004 with jr in slot1: push_valid=10, bypass_valid=1, no f2_flush even with bp_taken=1.
- queue_full:
  - Raised for 3 cycles while the register is valid and a new pair is offered: no push, input dropped, bypass=0.
  - After release: the held pair is pushed exactly once.
- Flush while valid and queue_full=0: push_valid=00, register empty next cycle. Reset asserted during hold: all outputs 0.
